// File: rtl/fabric_master_queue.sv
// fabric_master_queue
//   Per-master front end for one master port of the fabric arbiter. Requests
//   from the master are buffered in a DEPTH-entry FIFO and issued downstream
//   one at a time, so at most one transaction is outstanding. Responses are
//   forwarded upstream combinationally. A watchdog covers the outstanding
//   transaction: on expiry it returns TIMEOUT_CODE upstream, then waits for
//   the late slave response and discards it.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   up_req_*                request from the master (valid/ready + fields)
//   up_rsp_*                response to the master (valid/ready + fields)
//   dn_req_*                request to the arbiter, driven from the FIFO head
//   dn_rsp_*                response from the arbiter
//   fifo_level              registered FIFO occupancy
//   timeout_pulse           one-cycle strobe when the watchdog fires
//   discarding              high while a late response is awaited for discard
module fabric_master_queue #(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                ID_W           = 4,
  parameter int                OP_W           = 8,
  parameter int                SIZE_W         = 3,
  parameter int                ATTR_W         = 8,  // fabric attribute width
  parameter int                CODE_W         = 8,
  parameter int                DEPTH          = 4,  // power of two, >= 2
  parameter int                TIMEOUT_CYCLES = 1024,  // 0 disables the watchdog
  parameter logic [CODE_W-1:0] TIMEOUT_CODE   = 8'hFE
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // upstream request
  input  logic                     up_req_valid,
  output logic                     up_req_ready,
  input  logic [OP_W-1:0]          up_req_op,
  input  logic [ADDR_W-1:0]        up_req_addr,
  input  logic [DATA_W-1:0]        up_req_wdata,
  input  logic [DATA_W/8-1:0]      up_req_wstrb,
  input  logic [SIZE_W-1:0]        up_req_size,
  input  logic [ATTR_W-1:0]        up_req_attr,
  input  logic [ID_W-1:0]          up_req_id,
  // upstream response
  output logic                     up_rsp_valid,
  input  logic                     up_rsp_ready,
  output logic [DATA_W-1:0]        up_rsp_rdata,
  output logic [CODE_W-1:0]        up_rsp_code,
  output logic [ID_W-1:0]          up_rsp_id,
  // downstream request
  output logic                     dn_req_valid,
  input  logic                     dn_req_ready,
  output logic [OP_W-1:0]          dn_req_op,
  output logic [ADDR_W-1:0]        dn_req_addr,
  output logic [DATA_W-1:0]        dn_req_wdata,
  output logic [DATA_W/8-1:0]      dn_req_wstrb,
  output logic [SIZE_W-1:0]        dn_req_size,
  output logic [ATTR_W-1:0]        dn_req_attr,
  output logic [ID_W-1:0]          dn_req_id,
  // downstream response
  input  logic                     dn_rsp_valid,
  output logic                     dn_rsp_ready,
  input  logic [DATA_W-1:0]        dn_rsp_rdata,
  input  logic [CODE_W-1:0]        dn_rsp_code,
  input  logic [ID_W-1:0]          dn_rsp_id,
  // status
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     timeout_pulse,
  output logic                     discarding
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit WDOG_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] CNT_LIMIT =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef struct packed {
    logic [OP_W-1:0]     op;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic [SIZE_W-1:0]   size;
    logic [ATTR_W-1:0]   attr;
    logic [ID_W-1:0]     id;
  } req_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_TOUT,
    ST_DISCARD
  } state_t;

  req_t             mem_q [DEPTH];
  req_t             mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]  out_id_q, out_id_d;

  logic empty, full, push, pop;
  req_t head, req_in;

  assign empty        = (level_q == '0);
  assign full         = (level_q == LVL_W'(DEPTH));
  // Readiness uses only the registered level, so a full FIFO refuses a
  // request even in a cycle where the head is being dequeued.
  assign up_req_ready = !full;
  assign push         = up_req_valid && !full;
  assign fifo_level   = level_q;
  assign head         = mem_q[rd_ptr_q];
  assign req_in       = '{op: up_req_op, addr: up_req_addr, wdata: up_req_wdata,
                          wstrb: up_req_wstrb, size: up_req_size,
                          attr: up_req_attr, id: up_req_id};

  // FIFO datapath. DEPTH is a power of two, so pointers wrap naturally.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = req_in;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Issue / response / watchdog FSM.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    out_id_d      = out_id_q;
    pop           = 1'b0;
    dn_req_valid  = 1'b0;
    {dn_req_op, dn_req_addr, dn_req_wdata, dn_req_wstrb,
     dn_req_size, dn_req_attr, dn_req_id} = '0;
    up_rsp_valid  = 1'b0;
    up_rsp_rdata  = '0;
    up_rsp_code   = '0;
    up_rsp_id     = '0;
    dn_rsp_ready  = 1'b0;
    timeout_pulse = 1'b0;
    discarding    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        dn_req_valid = !empty;
        if (!empty) begin
          {dn_req_op, dn_req_addr, dn_req_wdata, dn_req_wstrb,
           dn_req_size, dn_req_attr, dn_req_id} = head;
          if (dn_req_ready) begin
            pop      = 1'b1;
            out_id_d = head.id;
            cnt_d    = '0;
            state_d  = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        up_rsp_valid = dn_rsp_valid;
        up_rsp_rdata = dn_rsp_rdata;
        up_rsp_code  = dn_rsp_code;
        up_rsp_id    = dn_rsp_id;
        dn_rsp_ready = up_rsp_ready;
        // A completing handshake beats the watchdog in the limit cycle; a
        // response stalled by up_rsp_ready keeps the watchdog running.
        if (dn_rsp_valid && up_rsp_ready) begin
          state_d = ST_IDLE;
        end else if (WDOG_EN && (cnt_q == CNT_LIMIT)) begin
          timeout_pulse = 1'b1;
          state_d       = ST_TOUT;
        end else if (WDOG_EN) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_TOUT: begin
        up_rsp_valid = 1'b1;
        up_rsp_code  = TIMEOUT_CODE;
        up_rsp_id    = out_id_q;
        if (up_rsp_ready) begin
          state_d = ST_DISCARD;
        end
      end

      ST_DISCARD: begin
        // The slave still owes a response; swallow it before issuing again.
        discarding   = 1'b1;
        dn_rsp_ready = 1'b1;
        if (dn_rsp_valid) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
      out_id_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      out_id_q <= out_id_d;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; an entry is only read after
  // it has been written, and the occupancy count gates every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: doc/fabric_master_queue.md
Name: fabric_master_queue

Overview:
- Per-master front-end stage that sits directly upstream of one master port of the M×N fabric arbiter.
- Buffers requests from a fabric master in a DEPTH-entry FIFO and issues them downstream one at a time (one outstanding, matching the arbiter's per-master limit).
- Forwards responses upstream.
- Guards each outstanding transaction with a response-timeout watchdog that injects an error response and later discards the late slave response.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (multiple of 8)
ID_W, 4, transaction id width
OP_W, 8, opcode width
SIZE_W, 3, size field width
ATTR_W, carbon_arch_pkg::CARBON_FABRIC_ATTR_WIDTH_BITS, attribute width
CODE_W, 8, response code width
DEPTH, 4, request FIFO entries; power of two, >=2
TIMEOUT_CYCLES, 1024, watchdog limit in cycles; 0 disables the watchdog
TIMEOUT_CODE, 8'hFE, rsp_code injected on timeout

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
up_req_valid / up_req_ready  in / out  1 / 1  upstream request handshake
up_req_op, up_req_addr, up_req_wdata, up_req_wstrb, up_req_size, up_req_attr, up_req_id  in  OP_W, ADDR_W, DATA_W, DATA_W/8, SIZE_W, ATTR_W, ID_W  request fields
up_rsp_valid / up_rsp_ready  out / in  1 / 1  upstream response handshake
up_rsp_rdata, up_rsp_code, up_rsp_id  out  DATA_W, CODE_W, ID_W  response fields
dn_req_valid / dn_req_ready  out / in  1 / 1  downstream (arbiter) request handshake
dn_req_op … dn_req_id  out  same widths as up_req_*  request fields
dn_rsp_valid / dn_rsp_ready  in / out  1 / 1  downstream response handshake
dn_rsp_rdata, dn_rsp_code, dn_rsp_id  in  DATA_W, CODE_W, ID_W  response fields
fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy
timeout_pulse  out  1  one-cycle pulse when a timeout fires
discarding  out  1  high while a late response is being awaited for discard

Behaviour:
- Reset (clk edge with rst_n=0): FIFO empty, state IDLE, counter 0. All outputs are 0 except up_req_ready=1 after the reset cycle.
- Reset mid-operation drops queued and outstanding transactions with no response.
- FIFO:
  - up_req_ready = !full. An enqueue occurs on up_req_valid&&up_req_ready.
  - No bypass: a request enqueued in cycle t is visible on dn_req_* at t+1 at the earliest.
  - dn_req_* is driven from the registered head entry. Fields are held stable while dn_req_valid=1 and !dn_req_ready.
  - Simultaneous enqueue and dequeue keeps the level unchanged. Pointers wrap modulo DEPTH.
  - When full, a new request is refused (up_req_ready=0) even if a dequeue occurs in the same cycle.
- FSM states: IDLE, WAIT, TOUT, DISCARD.
  - IDLE:
    - dn_req_valid = !empty; dn_rsp_ready=0; up_rsp_valid=0.
    - On the dn handshake: dequeue the head, latch its id into out_id, clear the counter, go to WAIT.
  - WAIT:
    - dn_req_valid=0.
    - Response path is combinational: up_rsp_* = dn_rsp_*, dn_rsp_ready = up_rsp_ready.
    - On dn_rsp_valid&&dn_rsp_ready, go to IDLE.
    - Otherwise the counter increments each cycle. When the counter reaches TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES>0), assert timeout_pulse and go to TOUT.
    - A response handshake in the same cycle as the limit wins: no timeout, go to IDLE.
    - A response that is valid but stalled by up_rsp_ready=0 still counts toward the timeout.
  - TOUT:
    - up_rsp_valid=1, up_rsp_code=TIMEOUT_CODE, up_rsp_id=out_id, up_rsp_rdata=0; dn_rsp_ready=0.
    - On up_rsp_ready, go to DISCARD.
  - DISCARD:
    - discarding=1; dn_rsp_ready=1; up_rsp_valid=0; dn_req_valid=0.
    - On dn_rsp_valid, swallow the response and go to IDLE.
    - No timeout applies here; the block waits indefinitely.
- fifo_level is the registered occupancy. timeout_pulse is asserted for exactly one cycle per timeout.
- With TIMEOUT_CYCLES=0, TOUT and DISCARD are unreachable.

Test Plan:
- Basic flow: DEPTH=4, push ids 1,2,3 back-to-back with dn_req_ready=1. Slave responds 2 cycles after each accept.
  → dn issues in order 1,2,3, never more than one outstanding. up_rsp ids 1,2,3 with codes passed through.
- Full FIFO: hold dn_req_ready=0, push 5 requests.
  → 4 accepted, up_req_ready=0 on the 5th, fifo_level=4. Release dn_req_ready → the 5th is accepted one cycle after the first dequeue.
- Timeout: TIMEOUT_CYCLES=8, issue id 5, no response.
  → timeout_pulse 8 cycles after the dn accept. up_rsp code 0xFE, id 5. Then discarding=1; a late dn_rsp is accepted and not forwarded; next queued request issues afterwards.
- Race: response handshake in exactly the limit cycle.
  → normal response forwarded, no timeout_pulse.
- Backpressure: up_rsp_ready=0 for 3 cycles in WAIT.
  → dn_rsp_ready=0 and up_rsp_* mirrors the stable dn_rsp_* fields. Handshake completes on release.
- Reset mid-WAIT with 2 queued entries.
  → next cycle: fifo_level=0, dn_req_valid=0, up_rsp_valid=0, state IDLE.
